// File: rtl/prince_round_ctrl.sv
// prince_round_ctrl: iterative PRINCE engine, one round per clock.
// Optional decryption is enabled with `define PRINCE_DECRYPT_EN.
module prince_round_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [63:0]  data_in,
    input  logic         decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
    localparam logic [63:0] SBOX  = 64'hbf32ac916780e5d4;
    localparam logic [63:0] SINV  = 64'hb732fd89a6405ec1;

    typedef enum logic [2:0] {
        IDLE, FWD, MID, BWD, FINAL, DONE
    } state_t;

    function automatic logic [63:0] rc(input logic [3:0] i);
        case (i)
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return ALPHA;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x,
                                            input logic inv);
        logic [63:0] y;
        logic [3:0]  v;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            v = x[4*n +: 4];
            y[4*n +: 4] = inv ? SINV[{~v, 2'b00} +: 4]
                              : SBOX[{~v, 2'b00} +: 4];
        end
        return y;
    endfunction

    // Block row j, column i uses m_k, k=(i+j+s)%4; m_k clears bit k
    // counted from the nibble MSB.
    function automatic logic [15:0] m_hat(input logic [15:0] x,
                                          input int s);
        logic [15:0] y;
        y = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                for (int b = 0; b < 4; b++)
                    if (b != 3 - ((i + j + s) % 4))
                        y[(3-j)*4+b] ^= x[(3-i)*4+b];
        return y;
    endfunction

    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 0), m_hat(x[47:32], 1),
                m_hat(x[31:16], 1), m_hat(x[15:0], 0)};
    endfunction

    // Nibble p (0 = MSB) takes nibble (p + 4*(p%4)) % 16.
    function automatic logic [63:0] shift_rows(input logic [63:0] x,
                                               input logic inv);
        logic [63:0] y;
        int q;
        y = '0;
        for (int p = 0; p < 16; p++) begin
            q = (p + 4 * (p % 4)) % 16;
            if (inv)
                y[60-4*q +: 4] = x[60-4*p +: 4];
            else
                y[60-4*p +: 4] = x[60-4*q +: 4];
        end
        return y;
    endfunction

    state_t      state, state_d;
    logic [63:0] sreg, sreg_d;
    logic [63:0] kout, kout_d;
    logic [63:0] k1r, k1r_d;
    logic [63:0] dout_d;
    logic [3:0]  rnd, rnd_d;
    logic        ov_d;
    logic        dec;

`ifdef PRINCE_DECRYPT_EN
    assign dec = decrypt;
`else
    logic unused_decrypt;
    assign dec = 1'b0;
    assign unused_decrypt = decrypt;
`endif

    logic [63:0] k0, k0p, k1a, kwi, kwo;
    logic [63:0] rc_cur, sm, fwd_v, mid_v, bwd_v;

    assign k0  = key_in[127:64];
    assign k0p = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
    assign k1a = dec ? (key_in[63:0] ^ ALPHA) : key_in[63:0];
    assign kwi = dec ? k0p : k0;
    assign kwo = dec ? k0 : k0p;

    assign rc_cur = rc(rnd);
    assign sm     = m_prime(s_layer(sreg, 1'b0));
    assign fwd_v  = shift_rows(sm, 1'b0) ^ rc_cur ^ k1r;
    assign mid_v  = s_layer(sm, 1'b1);
    assign bwd_v  = s_layer(m_prime(shift_rows(
                        sreg ^ k1r ^ rc_cur, 1'b1)), 1'b1);

    // Round sequencing, key capture and output handshake.
    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        kout_d   = kout;
        k1r_d    = k1r;
        rnd_d    = rnd;
        dout_d   = data_out;
        ov_d     = out_valid;
        in_ready = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    sreg_d  = data_in ^ kwi ^ k1a ^ rc(4'd0);
                    kout_d  = kwo;
                    k1r_d   = k1a;
                    rnd_d   = 4'd1;
                    state_d = FWD;
                end
            end
            FWD: begin
                sreg_d = fwd_v;
                rnd_d  = rnd + 4'd1;
                if (rnd == 4'd5)
                    state_d = MID;
            end
            MID: begin
                sreg_d  = mid_v;
                rnd_d   = 4'd6;
                state_d = BWD;
            end
            BWD: begin
                sreg_d = bwd_v;
                if (rnd == 4'd10) begin
                    rnd_d   = 4'd0;
                    state_d = FINAL;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end
            FINAL: begin
                dout_d  = sreg ^ rc(4'd11) ^ k1r ^ kout;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                rnd_d   = 4'd0;
                ov_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sreg      <= '0;
            kout      <= '0;
            k1r       <= '0;
            rnd       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            kout      <= kout_d;
            k1r       <= k1r_d;
            rnd       <= rnd_d;
            data_out  <= dout_d;
            out_valid <= ov_d;
        end
    end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// tb_prince_round_ctrl: random and directed checks of prince_round_ctrl
// against a cycle-level reference model of the PRINCE engine.
module tb_prince_round_ctrl;

    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
`ifdef PRINCE_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key_in = '0;
    logic [63:0]  data_in = '0;
    logic         decrypt = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  data_out;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prince_round_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .data_in   (data_in),
        .decrypt   (decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- PRINCE reference ----------------
    int sbx [16] = '{11, 15, 3, 2, 10, 12, 9, 1, 6, 7, 8, 0, 14, 5, 13, 4};
    int srp [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    logic [63:0] rcs [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344,
        64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
        64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa,
        64'hc882d32f25323c54, 64'h64a51195e0e3610d,
        64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

    function automatic logic [63:0] r_sl(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int v;
        y = '0;
        for (int p = 0; p < 16; p++) begin
            v = int'(x[60-4*p +: 4]);
            if (!inv) y[60-4*p +: 4] = 4'(sbx[v]);
            else
                for (int k = 0; k < 16; k++)
                    if (sbx[k] == v) y[60-4*p +: 4] = 4'(k);
        end
        return y;
    endfunction

    function automatic logic [63:0] r_sr(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y = '0;
        for (int p = 0; p < 16; p++)
            if (!inv) y[60-4*p +: 4] = x[60-4*srp[p] +: 4];
            else      y[60-4*srp[p] +: 4] = x[60-4*p +: 4];
        return y;
    endfunction

    // M' as a GF(2) matrix: each output bit is the parity of its row mask.
    function automatic logic [63:0] r_mp(input logic [63:0] x);
        logic [63:0] y;
        logic [15:0] xi, row;
        int t;
        y = '0;
        for (int blk = 0; blk < 4; blk++) begin
            t  = (blk == 1 || blk == 2) ? 1 : 0;
            xi = x[63-16*blk -: 16];
            for (int r = 0; r < 16; r++) begin
                row = '0;
                for (int i = 0; i < 4; i++)
                    if ((r / 4 + i + t) % 4 != r % 4)
                        row[15-(4*i + r % 4)] = 1'b1;
                y[63-16*blk-r] = ^(xi & row);
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] prince(input logic [63:0] d,
        input logic [63:0] kin, input logic [63:0] kout, input logic [63:0] k1);
        logic [63:0] s;
        s = d ^ kin ^ k1 ^ rcs[0];
        for (int i = 1; i <= 5; i++)
            s = r_sr(r_mp(r_sl(s, 0)), 0) ^ rcs[i] ^ k1;
        s = r_sl(r_mp(r_sl(s, 0)), 1);
        for (int i = 6; i <= 10; i++)
            s = r_sl(r_mp(r_sr(s ^ k1 ^ rcs[i], 1)), 1);
        return s ^ rcs[11] ^ k1 ^ kout;
    endfunction

    function automatic logic [63:0] expect_of(input logic [63:0] d,
        input logic [127:0] k, input logic dec);
        logic [63:0] k0, k0p, k1;
        k0  = k[127:64];
        k1  = k[63:0];
        k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);
        if (DEC_EN && dec) return prince(d, k0p, k0, k1 ^ ALPHA);
        return prince(d, k0, k0p, k1);
    endfunction

    // ---------------- cycle model ----------------
    bit          m_idle = 1'b1;
    bit          m_ov = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_dout = '0;
    logic [63:0] m_pend = '0;

    // Block accepted, result visible 12 edges later, released by out_ready.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_idle <= 1'b1;
            m_ov   <= 1'b0;
            m_cnt  <= 0;
            m_dout <= '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_cnt  <= 0;
                m_pend <= expect_of(data_in, key_in, decrypt);
            end
        end else if (!m_ov) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 12) begin
                m_ov   <= 1'b1;
                m_dout <= m_pend;
            end
        end else if (out_ready) begin
            m_ov   <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_idle);
        chk("busy", busy, !m_idle);
        chk("out_valid", out_valid, m_ov);
        chk("data_out", data_out, m_dout);
    end

    task automatic do_block(input logic [63:0] pt, input logic [127:0] key,
        input logic dec, input int hold, input logic [63:0] lit,
        input string nm);
        int k;
        int lat;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_ready"}, in_ready, 1'b1);
        chk({nm, "_model"}, expect_of(pt, key, dec), lit);
        in_valid  = 1'b1;
        data_in   = pt;
        key_in    = key;
        decrypt   = dec;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        data_in  = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd12);
        chk({nm, "_dout"}, data_out, lit);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom};
            @(negedge clk);
            chk({nm, "_hold_dout"}, data_out, lit);
            chk({nm, "_hold_ready"}, in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, in_ready, 1'b1);
    endtask

    localparam logic [127:0] KEY4 = {64'h0, 64'hfedcba9876543210};

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_block(64'h0, 128'h0, 1'b0, 0, 64'h818665aa0d02dfda, "vec1");
        do_block(64'hffffffffffffffff, 128'h0, 1'b0, 0,
                 64'h604ae6ca03c20ada, "vec2");
        do_block(64'h0, {64'hffffffffffffffff, 64'h0}, 1'b0, 0,
                 64'h9fb51935fc3df524, "vec3a");
        do_block(64'h0, {64'h0, 64'hffffffffffffffff}, 1'b0, 0,
                 64'h78a54cbe737bb7ef, "vec3b");
        do_block(64'h0123456789abcdef, KEY4, 1'b0, 5,
                 64'hae25ad3ca8fa9ccf, "vec4");

        // Reset in the middle of a block.
        in_valid = 1'b1;
        data_in  = 64'h0123456789abcdef;
        key_in   = KEY4;
        decrypt  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_data_out", data_out, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_block(64'h0123456789abcdef, KEY4, 1'b0, 0,
                 64'hae25ad3ca8fa9ccf, "vec5");

`ifdef PRINCE_DECRYPT_EN
        do_block(64'hae25ad3ca8fa9ccf, KEY4, 1'b1, 0,
                 64'h0123456789abcdef, "vec6_dec");
`else
        do_block(64'h0123456789abcdef, KEY4, 1'b1, 0,
                 64'hae25ad3ca8fa9ccf, "vec6_nodec");
`endif

        // Random traffic with random handshakes.
        repeat (1500) begin
            @(negedge clk);
            in_valid  = ($urandom % 2) == 0;
            data_in   = {$urandom, $urandom};
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            decrypt   = ($urandom % 2) == 0;
            out_ready = ($urandom % 3) != 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_idle", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
